piso_frame_tx: RTL
==================

Name: piso_frame_tx

Overview:
- Parallel-in/serial-out framed transmitter that produces the single-bit d_i-style stream consumed by the flip-flop and shift-register blocks.
- Accepts a parallel word through a valid/ready handshake.
- Emits one start bit, the data bits LSB first, an optional even-parity bit and one stop bit, one bit per clock.
- Serves as the synthesizable stimulus source for serial sinks, replacing hand-written bench stimulus.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..32).
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_i  input  DATA_W  parallel word to transmit.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a word this cycle.
- d_o  output  1  registered serial output; idle level 1.
- busy_o  output  1  frame in progress (START through STOP).
- done_o  output  1  one-cycle pulse during the stop-bit cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, d_o=1, busy_o=0, done_o=0, bit counter=0, shadow register=0.
  - All inputs are ignored while rst=0.
  - Reset mid-frame aborts the frame immediately. d_o returns to 1 without waiting for a clock edge, and no done_o is issued.
- States: IDLE, START, DATA, PARITY (only when PARITY_EN=1), STOP.
- ready_o is combinational: 1 in IDLE or STOP, 0 otherwise.
- Accept: valid_i && ready_o at rising edge k.
  - data_i is captured into the shadow register.
  - From edge k: state=START, d_o=0, busy_o=1.
  - data_i may change after edge k with no effect on the frame.
- DATA: after edge k+1+n, d_o = shadow[n] for n = 0..DATA_W-1 (LSB first). The bit counter counts 0..DATA_W-1.
- PARITY: d_o = XOR of the shadow bits for one cycle.
- STOP: d_o=1 and done_o=1 for exactly one cycle.
  - If valid_i is high during STOP, the next START follows with no idle gap.
  - Otherwise the next state is IDLE with busy_o=0.
- Frame length = DATA_W+2+PARITY_EN cycles. Start-to-stop timing is fixed; there is no backpressure inside a frame.
- valid_i asserted while ready_o=0 is ignored and data_i is not captured. The sender holds valid_i until it is accepted.
- d_o, busy_o and done_o are registered outputs with no combinational path from any input.
- Counter width is $clog2(DATA_W). The counter never wraps past DATA_W-1; DATA exits on its last value.

Decomposition:
- Shared package piso_pkg holds:
  - the state typedef (IDLE/START/DATA/PARITY/STOP);
  - localparam IDLE_LEVEL=1'b1;
  - the function frame_len(DATA_W, PARITY_EN).
- Sub-module piso_shift_reg (load, shift enable, LSB out, DATA_W wide) holds the shadow word. The FSM and counter stay in piso_frame_tx.

Test Plan:
- Reset: rst=0 for 3 cycles with valid_i=1 -> d_o=1, busy_o=0, done_o=0, ready_o=1, nothing accepted.
- Single frame: DATA_W=8, data 8'hA5 with valid for 1 cycle -> d_o = 0,1,0,1,0,0,1,0,1,1 over 10 cycles, done_o high on cycle 10 only, then IDLE.
- Back-to-back: 8'h3C then 8'hFF, valid held -> 20 contiguous frame cycles, second start bit directly after the first stop bit, two done_o pulses 10 cycles apart.
- Parity: PARITY_EN=1, 8'h07 -> 11-cycle frame, parity bit = 1, stop = 1.
- Ignored input: send 8'h00; during its data phase drive valid_i=1 with data_i=8'h55 -> d_o stays all-zero data, 8'h55 is sent only after the STOP/ready window.
- Reset mid-frame: rst=0 during data bit 3 of 8'hF0 -> d_o=1 asynchronously, no done_o. After release, 8'h81 transmits as 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the framed parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Cycles from start bit through stop bit inclusive.
  function automatic int frame_len(input int data_w, input int parity_en);
    return data_w + 2 + parity_en;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Shadow word for one frame. Shifting rotates, so the word is intact again
// after DATA_W shifts and parity stays available throughout the frame.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_lsb,
  output logic              o_par
);

  logic [DATA_W-1:0] r_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_data;
    end else if (i_shift) begin
      r_word <= {r_word[0], r_word[DATA_W-1:1]};
    end
  end

  assign o_lsb = r_word[0];
  assign o_par = ^r_word;

endmodule

// File: rtl/piso_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W bits LSB first, optional even
// parity, stop bit. Accepts a word via valid/ready in IDLE or during STOP.
module piso_frame_tx
  import piso_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              d_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_accept, w_load, w_shift, w_lsb, w_par, w_d_nxt;
  logic             r_d, r_busy, r_done;

  assign ready_o  = (r_state == IDLE) || (r_state == STOP);
  assign w_accept = valid_i && ready_o;

  piso_shift_reg #(.DATA_W(DATA_W)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (data_i),
    .o_lsb   (w_lsb),
    .o_par   (w_par)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_d_nxt     = IDLE_LEVEL;
    case (r_state)
      IDLE, STOP: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        w_state_nxt = DATA;
        w_shift     = 1'b1;
        w_cnt_nxt   = '0;
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          w_cnt_nxt   = '0;
        end else begin
          w_shift   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PARITY:  w_state_nxt = STOP;
      default: w_state_nxt = IDLE;
    endcase
    // Output bits are registered from the state being entered, so d_o
    // always reflects the current state with no input-to-output path.
    case (w_state_nxt)
      START:   w_d_nxt = 1'b0;
      DATA:    w_d_nxt = w_lsb;
      PARITY:  w_d_nxt = w_par;
      default: w_d_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_d    <= IDLE_LEVEL;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_d    <= w_d_nxt;
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == STOP);
    end
  end

  assign d_o    = r_d;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule
